frontend_redirect_arbiter: RTL and testbench
============================================

// Module: frontend_redirect_arbiter
// PURPOSE
//  Collects every PC-redirect source of the frontend and serialises them into one
//  registered redirect request per cycle, with a valid/ready handshake into the
//  next-PC generator. Sources: debug, commit flush, exception, eret, mispredict,
//  replay, branch predict.
//  Also sequences the boot fetch, holds a redirect that is not yet accepted, and
//  tags each accepted redirect with a fetch epoch so fetch can drop stale responses.
// PARAMETERS
//  CVA6Cfg   config_pkg::cva6_cfg_empty  DmBaseAddress/HaltAddress for the debug target
//  EPOCH_W   2                           width of the fetch-epoch counter
// PORTS
//  clk_i              in   1     clock
//  rst_ni             in   1     asynchronous reset, active low
//  flush_i            in   1     drop pending frontend-class (replay/bp) redirect
//  halt_i             in   1     commit halted: commit target is pc_commit_i, not +4
//  boot_addr_i        in   VLEN  boot PC
//  resolved_branch_i  in   bp_resolve_t  mispredict = valid & is_mispredict
//  set_pc_commit_i    in   1     commit flush request
//  pc_commit_i        in   VLEN  PC in commit
//  eret_i             in   1     return from exception
//  epc_i              in   VLEN  eret target
//  ex_valid_i         in   1     exception/interrupt
//  trap_vector_base_i in   VLEN  exception target
//  set_debug_pc_i     in   1     debug entry
//  replay_i           in   1     fetch replay
//  replay_addr_i      in   VLEN  replay target
//  bp_valid_i         in   1     predicted taken
//  predict_address_i  in   VLEN  prediction target
//  redir_ready_i      in   1     next-PC generator accepts the redirect
//  redir_valid_o      out  1     redirect request valid
//  redir_addr_o       out  VLEN  redirect target
//  redir_cause_o      out  3     redir_cause_e of the held redirect
//  kill_fetch_o       out  1     1-cycle pulse: in-flight fetches must be squashed
//  epoch_o            out  EPOCH_W  current fetch epoch
// BEHAVIOUR
//  Reset: state RST; redir_valid_o=0, redir_addr_o=0, redir_cause_o=CAUSE_NONE,
//   kill_fetch_o=0, epoch_o=0.
//  Priority, high to low, with the target for each source:
//   DEBUG  : DmBaseAddress+HaltAddress
//   COMMIT : pc_commit_i + (halt_i ? 0 : 4)
//   EXC    : trap_vector_base_i
//   ERET   : epc_i
//   MISPRED: target_address
//   REPLAY : replay_addr_i
//   BP     : predict_address_i
//  Causes MISPRED and above are backend-class.
//  Target adds are VLEN-bit, wrapping; no carry out.
//  Latency: a request in cycle N is visible on the outputs in N+1.
//   All outputs are registered.
//  FSM:
//   RST  -> BOOT unconditionally.
//   BOOT : valid=1, addr=boot_addr_i, cause=CAUSE_BOOT.
//     A DEBUG request in BOOT replaces the held redirect and moves to PEND.
//     All other requests in BOOT are dropped.
//     On ready (and no DEBUG) -> IDLE.
//   IDLE : any request -> capture the winner and go to PEND.
//     If nothing is captured, valid=0.
//   PEND : valid=1, and the held addr/cause stay stable while ready=0.
//     ready=1 with no new request -> IDLE.
//     ready=1 with a new request -> capture it and stay in PEND.
//     ready=0 with a new request of priority >= the held one -> overwrite.
//     ready=0 with a new request of lower priority -> drop it.
//  Handshake: transfer when valid & ready.
//   epoch_o increments on every transfer, wrapping mod 2^EPOCH_W.
//  kill_fetch_o is high in the first cycle a backend-class redirect is valid.
//   This covers a fresh capture and an overwrite. It is not repeated while held.
//  flush_i: clears a held REPLAY/BP redirect (PEND -> IDLE, valid=0 next cycle).
//   It suppresses REPLAY/BP requests in the same cycle.
//   A backend-class request in the same cycle as flush_i is still captured.
//  Simultaneous requests: only the winner is kept; losers are dropped.
//   The backend re-requests as needed.
//  Reset mid-operation: returns to RST immediately. The held redirect and epoch are lost.
// STRUCTURE
//  ariane_pkg: redir_cause_e, 3-bit, values
//   NONE=0, BP=1, REPLAY=2, MISPRED=3, ERET=4, EXC=5, COMMIT=6, DEBUG=7.
//   Encoding order equals priority, so priority compare is a numeric compare.
//   Also in ariane_pkg: redir_req_t {addr, cause}.
//  Sub-module redirect_prio_sel: combinational.
//   Takes the raw requests and returns the winning redir_req_t.
//  The FSM, holding register and epoch counter stay in this module.
// TESTING
//  1. Reset release, ready=1 in the second cycle:
//     valid rises 1 cycle after RST with addr=boot_addr_i (0x8000_0000) and cause BOOT.
//     Then IDLE, epoch=1.
//  2. ex_valid_i with trap_vector_base_i=0x100 in the same cycle as bp_valid_i (0x2000):
//     next cycle addr=0x100, cause EXC, kill_fetch_o=1.
//  3. Hold ready=0 with MISPRED (0x400) held, then eret_i (epc 0x800):
//     addr becomes 0x800 with kill pulsing again.
//     A later bp_valid_i is dropped and 0x800 is held.
//  4. set_pc_commit_i with pc_commit_i=0x1000:
//     halt_i=0 gives addr 0x1004; halt_i=1 gives addr 0x1000.
//     Commit at 0xFFFF_FFFC with halt_i=0 wraps to 0x0.
//  5. replay_i held, ready=0, flush_i=1:
//     next cycle valid=0 and epoch unchanged.
//     flush_i together with ex_valid_i still captures EXC.
//  6. Four back-to-back accepted redirects with EPOCH_W=2: epoch goes 1,2,3,0.
//     set_debug_pc_i during BOOT: addr=DmBase+Halt, boot fetch is replaced.

Source files
------------

// File: rtl/frontend_redirect_arbiter_pkg.sv
// Shared types for the frontend redirect arbiter: redirect causes, the request
// record, the branch-resolve bundle and the debug-target configuration.
package frontend_redirect_arbiter_pkg;

  localparam int unsigned VLEN = 32;
  typedef logic [VLEN-1:0] vaddr_t;

  // Encoding order equals priority, so a priority compare is a numeric compare.
  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_BP      = 3'd1,
    CAUSE_REPLAY  = 3'd2,
    CAUSE_MISPRED = 3'd3,
    CAUSE_ERET    = 3'd4,
    CAUSE_EXC     = 3'd5,
    CAUSE_COMMIT  = 3'd6,
    CAUSE_DEBUG   = 3'd7
  } redir_cause_e;

  // The boot fetch is told apart from an idle output by valid=1; it shares code 0.
  localparam redir_cause_e CAUSE_BOOT = CAUSE_NONE;

  typedef struct packed {
    vaddr_t       addr;
    redir_cause_e cause;
  } redir_req_t;

  typedef struct packed {
    logic   valid;
    logic   is_mispredict;
    vaddr_t target_address;
  } bp_resolve_t;

  typedef struct packed {
    vaddr_t dm_base_address;
    vaddr_t halt_address;
  } cva6_cfg_t;

  localparam cva6_cfg_t CVA6_CFG_EMPTY = '{
    dm_base_address: vaddr_t'(0),
    halt_address:    vaddr_t'(32'h0000_0800)
  };

  function automatic logic is_backend(redir_cause_e cause);
    return cause >= CAUSE_MISPRED;
  endfunction

endpackage

// File: rtl/frontend_redirect_arbiter_if.sv
// Redirect handshake from the arbiter (master) into the next-PC generator (slave).
interface frontend_redirect_arbiter_if #(
  parameter int unsigned EPOCH_W = 2
);
  import frontend_redirect_arbiter_pkg::*;

  logic               valid;
  logic               ready;
  vaddr_t             addr;
  redir_cause_e       cause;
  logic               kill_fetch;
  logic [EPOCH_W-1:0] epoch;

  modport master (output valid, addr, cause, kill_fetch, epoch, input ready);
  modport slave  (input valid, addr, cause, kill_fetch, epoch, output ready);
endinterface

// File: rtl/frontend_redirect_arbiter_prio_sel.sv
// Combinational fixed-priority pick among all raw redirect requests; returns the
// winner with its target, or CAUSE_NONE when nothing requests.
module redirect_prio_sel
  import frontend_redirect_arbiter_pkg::*;
#(
  parameter vaddr_t DEBUG_ADDR = '0
) (
  input  logic        flush_i,
  input  logic        halt_i,
  input  bp_resolve_t resolved_branch_i,
  input  logic        set_pc_commit_i,
  input  vaddr_t      pc_commit_i,
  input  logic        eret_i,
  input  vaddr_t      epc_i,
  input  logic        ex_valid_i,
  input  vaddr_t      trap_vector_base_i,
  input  logic        set_debug_pc_i,
  input  logic        replay_i,
  input  vaddr_t      replay_addr_i,
  input  logic        bp_valid_i,
  input  vaddr_t      predict_address_i,
  output redir_req_t  win_o
);

  logic mispredict;
  assign mispredict = resolved_branch_i.valid & resolved_branch_i.is_mispredict;

  // NOTE: a default before the if-chain keeps every path assigned, so no latch is inferred.
  always_comb begin
    win_o = '{addr: '0, cause: CAUSE_NONE};
    if (set_debug_pc_i) begin
      win_o = '{addr: DEBUG_ADDR, cause: CAUSE_DEBUG};
    end else if (set_pc_commit_i) begin
      win_o = '{addr: pc_commit_i + (halt_i ? vaddr_t'(0) : vaddr_t'(4)), cause: CAUSE_COMMIT};
    end else if (ex_valid_i) begin
      win_o = '{addr: trap_vector_base_i, cause: CAUSE_EXC};
    end else if (eret_i) begin
      win_o = '{addr: epc_i, cause: CAUSE_ERET};
    end else if (mispredict) begin
      win_o = '{addr: resolved_branch_i.target_address, cause: CAUSE_MISPRED};
    end else if (replay_i && !flush_i) begin
      win_o = '{addr: replay_addr_i, cause: CAUSE_REPLAY};
    end else if (bp_valid_i && !flush_i) begin
      win_o = '{addr: predict_address_i, cause: CAUSE_BP};
    end
  end

endmodule

// File: rtl/frontend_redirect_arbiter.sv
// Serialises all frontend PC-redirect sources into one registered, held redirect
// with a valid/ready handshake, boot sequencing and a fetch epoch per transfer.
module frontend_redirect_arbiter
  import frontend_redirect_arbiter_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg = CVA6_CFG_EMPTY,
  parameter int unsigned EPOCH_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        halt_i,
  input  vaddr_t      boot_addr_i,
  input  bp_resolve_t resolved_branch_i,
  input  logic        set_pc_commit_i,
  input  vaddr_t      pc_commit_i,
  input  logic        eret_i,
  input  vaddr_t      epc_i,
  input  logic        ex_valid_i,
  input  vaddr_t      trap_vector_base_i,
  input  logic        set_debug_pc_i,
  input  logic        replay_i,
  input  vaddr_t      replay_addr_i,
  input  logic        bp_valid_i,
  input  vaddr_t      predict_address_i,
  frontend_redirect_arbiter_if.master redir
);

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_BOOT = 2'd1;
  localparam logic [1:0] ST_IDLE = 2'd2;
  localparam logic [1:0] ST_PEND = 2'd3;

  localparam vaddr_t DEBUG_ADDR = vaddr_t'(CVA6Cfg.dm_base_address + CVA6Cfg.halt_address);

  logic [1:0]         state_q, state_d;
  logic               valid_q, valid_d;
  vaddr_t             addr_q, addr_d;
  redir_cause_e       cause_q, cause_d;
  logic               kill_q, kill_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               fire, capture;
  redir_req_t         win;

  redirect_prio_sel #(.DEBUG_ADDR(DEBUG_ADDR)) i_prio_sel (
    .flush_i            (flush_i),
    .halt_i             (halt_i),
    .resolved_branch_i  (resolved_branch_i),
    .set_pc_commit_i    (set_pc_commit_i),
    .pc_commit_i        (pc_commit_i),
    .eret_i             (eret_i),
    .epc_i              (epc_i),
    .ex_valid_i         (ex_valid_i),
    .trap_vector_base_i (trap_vector_base_i),
    .set_debug_pc_i     (set_debug_pc_i),
    .replay_i           (replay_i),
    .replay_addr_i      (replay_addr_i),
    .bp_valid_i         (bp_valid_i),
    .predict_address_i  (predict_address_i),
    .win_o              (win)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    cause_d = cause_q;
    kill_d  = 1'b0;
    capture = 1'b0;
    fire    = valid_q & redir.ready;
    epoch_d = epoch_q + EPOCH_W'(fire);

    case (state_q)
      ST_RST: begin
        state_d = ST_BOOT;
        valid_d = 1'b1;
        addr_d  = boot_addr_i;
        cause_d = CAUSE_BOOT;
      end
      // Only debug may displace the boot fetch; everything else is dropped.
      ST_BOOT: begin
        if (win.cause == CAUSE_DEBUG) begin
          capture = 1'b1;
        end else if (redir.ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_IDLE: capture = (win.cause != CAUSE_NONE);
      ST_PEND: begin
        if (redir.ready) begin
          if (win.cause != CAUSE_NONE) begin
            capture = 1'b1;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end else if (win.cause != CAUSE_NONE && win.cause >= cause_q) begin
          capture = 1'b1;
        end else if (flush_i && !is_backend(cause_q)) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = ST_RST;
    endcase

    if (capture) begin
      state_d = ST_PEND;
      valid_d = 1'b1;
      addr_d  = win.addr;
      cause_d = win.cause;
      kill_d  = is_backend(win.cause);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RST;
      valid_q <= 1'b0;
      addr_q  <= '0;
      cause_q <= CAUSE_NONE;
      kill_q  <= 1'b0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      cause_q <= cause_d;
      kill_q  <= kill_d;
      epoch_q <= epoch_d;
    end
  end

  assign redir.valid      = valid_q;
  assign redir.addr       = addr_q;
  assign redir.cause      = cause_q;
  assign redir.kill_fetch = kill_q;
  assign redir.epoch      = epoch_q;

endmodule

// File: tb/tb_frontend_redirect_arbiter.sv
// Scoreboard bench: each step pushes the hand-derived expected outputs, then the
// registered DUT response one edge later is popped and compared.
module tb_frontend_redirect_arbiter;
  import frontend_redirect_arbiter_pkg::*;

  localparam cva6_cfg_t TB_CFG = '{
    dm_base_address: vaddr_t'(32'h1A11_0000),
    halt_address:    vaddr_t'(32'h0000_0800)
  };

  typedef struct {
    string        tag;
    logic         valid;
    vaddr_t       addr;
    redir_cause_e cause;
    logic         kill;
    logic [1:0]   epoch;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, halt_i, set_pc_commit_i, eret_i, ex_valid_i;
  logic        set_debug_pc_i, replay_i, bp_valid_i;
  vaddr_t      boot_addr_i, pc_commit_i, epc_i, trap_vector_base_i;
  vaddr_t      replay_addr_i, predict_address_i;
  bp_resolve_t resolved_branch_i;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  frontend_redirect_arbiter_if #(.EPOCH_W(2)) redir ();

  frontend_redirect_arbiter #(.CVA6Cfg(TB_CFG), .EPOCH_W(2)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .halt_i             (halt_i),
    .boot_addr_i        (boot_addr_i),
    .resolved_branch_i  (resolved_branch_i),
    .set_pc_commit_i    (set_pc_commit_i),
    .pc_commit_i        (pc_commit_i),
    .eret_i             (eret_i),
    .epc_i              (epc_i),
    .ex_valid_i         (ex_valid_i),
    .trap_vector_base_i (trap_vector_base_i),
    .set_debug_pc_i     (set_debug_pc_i),
    .replay_i           (replay_i),
    .replay_addr_i      (replay_addr_i),
    .bp_valid_i         (bp_valid_i),
    .predict_address_i  (predict_address_i),
    .redir              (redir)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    flush_i = 0; halt_i = 0; set_pc_commit_i = 0; eret_i = 0; ex_valid_i = 0;
    set_debug_pc_i = 0; replay_i = 0; bp_valid_i = 0;
    pc_commit_i = '0; epc_i = '0; trap_vector_base_i = '0;
    replay_addr_i = '0; predict_address_i = '0;
    resolved_branch_i = '0;
  endtask

  // Push expectation, advance one edge, then pop and compare away from the edge.
  task automatic step(input string tag, input logic v, input vaddr_t a,
                      input redir_cause_e c, input logic k, input logic [1:0] e);
    exp_t x;
    sb_q.push_back('{tag: tag, valid: v, addr: a, cause: c, kill: k, epoch: e});
    @(posedge clk_i);
    #1;
    x = sb_q.pop_front();
    check({x.tag, ".valid"}, 64'(redir.valid), 64'(x.valid));
    if (x.valid) begin
      check({x.tag, ".addr"}, 64'(redir.addr), 64'(x.addr));
      check({x.tag, ".cause"}, 64'(redir.cause), 64'(x.cause));
    end
    check({x.tag, ".kill"}, 64'(redir.kill_fetch), 64'(x.kill));
    check({x.tag, ".epoch"}, 64'(redir.epoch), 64'(x.epoch));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, 64'(redir.valid), 64'd0);
    check({tag, ".addr"}, 64'(redir.addr), 64'd0);
    check({tag, ".cause"}, 64'(redir.cause), 64'(CAUSE_NONE));
    check({tag, ".kill"}, 64'(redir.kill_fetch), 64'd0);
    check({tag, ".epoch"}, 64'(redir.epoch), 64'd0);
  endtask

  initial begin
    clr();
    rst_ni      = 1'b0;
    redir.ready = 1'b0;
    boot_addr_i = 32'h8000_0000;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_state("rst");

    // 1: boot fetch, accepted on the second cycle
    rst_ni = 1'b1;
    step("t1.boot", 1, 32'h8000_0000, CAUSE_BOOT, 0, 2'd0);
    redir.ready = 1'b1;
    step("t1.acc", 0, '0, CAUSE_NONE, 0, 2'd1);

    // 2: exception beats branch prediction in the same cycle
    redir.ready = 1'b0;
    ex_valid_i = 1; trap_vector_base_i = 32'h100;
    bp_valid_i = 1; predict_address_i = 32'h2000;
    step("t2.exc", 1, 32'h100, CAUSE_EXC, 1, 2'd1);
    clr();
    step("t2.hold", 1, 32'h100, CAUSE_EXC, 0, 2'd1);
    redir.ready = 1'b1;
    step("t2.acc", 0, '0, CAUSE_NONE, 0, 2'd2);

    // 3: mispredict held, overwritten by eret, later bp dropped
    redir.ready = 1'b0;
    resolved_branch_i = '{valid: 1'b1, is_mispredict: 1'b1, target_address: 32'h400};
    step("t3.misp", 1, 32'h400, CAUSE_MISPRED, 1, 2'd2);
    clr();
    step("t3.hold", 1, 32'h400, CAUSE_MISPRED, 0, 2'd2);
    eret_i = 1; epc_i = 32'h800;
    step("t3.eret", 1, 32'h800, CAUSE_ERET, 1, 2'd2);
    clr();
    bp_valid_i = 1; predict_address_i = 32'h2000;
    step("t3.bpdrop", 1, 32'h800, CAUSE_ERET, 0, 2'd2);
    clr();
    redir.ready = 1'b1;
    step("t3.acc", 0, '0, CAUSE_NONE, 0, 2'd3);

    // 4: commit targets, halt and address wrap; back-to-back accepts
    redir.ready = 1'b0;
    set_pc_commit_i = 1; pc_commit_i = 32'h1000; halt_i = 0;
    step("t4.plus4", 1, 32'h1004, CAUSE_COMMIT, 1, 2'd3);
    redir.ready = 1'b1; halt_i = 1;
    step("t4.halt", 1, 32'h1000, CAUSE_COMMIT, 1, 2'd0);
    halt_i = 0; pc_commit_i = 32'hFFFF_FFFC;
    step("t4.wrap", 1, 32'h0, CAUSE_COMMIT, 1, 2'd1);
    clr();
    step("t4.acc", 0, '0, CAUSE_NONE, 0, 2'd2);

    // 5: flush clears held replay; backend request alongside flush survives
    redir.ready = 1'b0;
    replay_i = 1; replay_addr_i = 32'h3000;
    step("t5.replay", 1, 32'h3000, CAUSE_REPLAY, 0, 2'd2);
    flush_i = 1;
    step("t5.flush", 0, '0, CAUSE_NONE, 0, 2'd2);
    ex_valid_i = 1; trap_vector_base_i = 32'h100;
    step("t5.flushexc", 1, 32'h100, CAUSE_EXC, 1, 2'd2);
    clr();
    redir.ready = 1'b1;
    step("t5.acc", 0, '0, CAUSE_NONE, 0, 2'd3);

    // reset mid-operation drops the held redirect and the epoch
    redir.ready = 1'b0;
    bp_valid_i = 1; predict_address_i = 32'h2000;
    step("rr.bp", 1, 32'h2000, CAUSE_BP, 0, 2'd3);
    clr();
    rst_ni = 1'b0;
    #1;
    check_reset_state("rr.async");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // 6: non-debug dropped in BOOT, debug replaces boot, then four transfers
    step("t6.boot", 1, 32'h8000_0000, CAUSE_BOOT, 0, 2'd0);
    ex_valid_i = 1; trap_vector_base_i = 32'h100;
    step("t6.bootdrop", 1, 32'h8000_0000, CAUSE_BOOT, 0, 2'd0);
    clr();
    set_debug_pc_i = 1;
    step("t6.debug", 1, 32'h1A11_0800, CAUSE_DEBUG, 1, 2'd0);
    clr();
    redir.ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      eret_i = 1; epc_i = vaddr_t'(i * 16);
      step($sformatf("t6.b2b%0d", i), 1, vaddr_t'(i * 16), CAUSE_ERET, 1, 2'(i));
    end
    clr();
    step("t6.b2b4", 0, '0, CAUSE_NONE, 0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
